// File: rtl/dac_frame_sequencer_pkg.sv
// Shared definitions for the DAC frame sequencer: FSM encoding, DAC word layout,
// channel addresses and default command codes.
package dac_frame_sequencer_pkg;

   localparam int WORD_W   = 24;
   localparam int CODE_W   = 16;
   localparam int CNT_W    = 8;
   localparam int NUM_CH   = 2;

   localparam int CMD_MSB  = 21;
   localparam int CMD_LSB  = 19;
   localparam int ADDR_MSB = 18;
   localparam int ADDR_LSB = 16;

   localparam logic [2:0] ADDR_A    = 3'b000;
   localparam logic [2:0] ADDR_B    = 3'b001;
   localparam logic [2:0] CMD_A_DEF = 3'b000;
   localparam logic [2:0] CMD_B_DEF = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_HOLDOFF
   } state_e;

   typedef struct packed {
      logic [CODE_W-1:0] l;
      logic [CODE_W-1:0] r;
   } pair_t;

endpackage

// File: rtl/dac_frame_sequencer_if.sv
// Sample-in / serializer-out bundle of the DAC frame sequencer.
// master = sample source + serializer side, slave = the sequencer.
interface dac_frame_sequencer_if;
   import dac_frame_sequencer_pkg::*;

   logic [CODE_W-1:0] i_sample_l;
   logic [CODE_W-1:0] i_sample_r;
   logic              i_sample_valid;
   logic              i_spi_cs;
   logic [WORD_W-1:0] o_data;
   logic              o_send;
   logic              o_busy;
   logic              o_overrun;
   logic              o_error;

   modport master (
      output i_sample_l, i_sample_r, i_sample_valid, i_spi_cs,
      input  o_data, o_send, o_busy, o_overrun, o_error
   );

   modport slave (
      input  i_sample_l, i_sample_r, i_sample_valid, i_spi_cs,
      output o_data, o_send, o_busy, o_overrun, o_error
   );

endinterface

// File: rtl/dac_word_format.sv
// Combinational sample-to-DAC-word conversion: optional two's complement to
// offset binary, then command/address/code packing.
module dac_word_format
   import dac_frame_sequencer_pkg::*;
#(
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic [CODE_W-1:0] sample_i,
   input  logic [2:0]        cmd_i,
   input  logic [2:0]        addr_i,
   output logic [WORD_W-1:0] word_o
);

   logic [CODE_W-1:0] code;

   // Flipping the sign bit maps -32768..32767 onto 0..65535.
   assign code = SIGNED_IN ? {~sample_i[CODE_W-1], sample_i[CODE_W-2:0]} : sample_i;

   always_comb begin
      word_o                    = '0;
      word_o[CMD_MSB:CMD_LSB]   = cmd_i;
      word_o[ADDR_MSB:ADDR_LSB] = addr_i;
      word_o[CODE_W-1:0]        = code;
   end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Turns captured stereo pairs into two paced serializer words (A, then B with
// update-all), throttled by the serializer's chip-select feedback.
module dac_frame_sequencer
   import dac_frame_sequencer_pkg::*;
#(
   parameter bit         SIGNED_IN   = 1'b1,
   parameter int         ACK_TIMEOUT = 4,
   parameter int         HOLDOFF     = 24,
   parameter logic [2:0] CMD_A       = CMD_A_DEF,
   parameter logic [2:0] CMD_B       = CMD_B_DEF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   dac_frame_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   pair_t             pair_q, pair_d;
   pair_t             work_q, work_d;
   logic              ch_q, ch_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              ovr_q, ovr_d;
   logic              consume;

   logic [NUM_CH-1:0][CODE_W-1:0] lane_sample;
   logic [NUM_CH-1:0][2:0]        lane_cmd;
   logic [NUM_CH-1:0][2:0]        lane_addr;
   logic [NUM_CH-1:0][WORD_W-1:0] lane_word;
   logic [WORD_W-1:0]             word_now;

   assign lane_sample = {work_q.r, work_q.l};
   assign lane_cmd    = {CMD_B, CMD_A};
   assign lane_addr   = {ADDR_B, ADDR_A};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      dac_word_format #(.SIGNED_IN(SIGNED_IN)) u_fmt (
         .sample_i (lane_sample[g]),
         .cmd_i    (lane_cmd[g]),
         .addr_i   (lane_addr[g]),
         .word_o   (lane_word[g])
      );
   end

   assign word_now = lane_word[ch_q];
   assign consume  = (state_q == ST_IDLE) && pend_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         pair_q  <= '0;
         work_q  <= '0;
         ch_q    <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         pair_q  <= pair_d;
         work_q  <= work_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (pend_q) state_d = ST_ISSUE;
         ST_ISSUE:     state_d = ST_WAIT_ACK;
         ST_WAIT_ACK:  if (!bus.i_spi_cs) state_d = ST_WAIT_DONE;
                       else if (cnt_q == ACK_LAST) state_d = ST_IDLE;
         ST_WAIT_DONE: if (bus.i_spi_cs) state_d = ST_HOLDOFF;
         ST_HOLDOFF:   if (cnt_q == HOLD_LAST) state_d = ch_q ? ST_IDLE : ST_ISSUE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // A strobe in the consuming IDLE cycle lands in the freed slot: no overrun.
   always_comb begin
      pend_d = pend_q;
      pair_d = pair_q;
      work_d = work_q;
      ch_d   = ch_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      ovr_d  = bus.i_sample_valid && pend_q && !consume;
      if (bus.i_sample_valid) begin
         pend_d = 1'b1;
         pair_d = {bus.i_sample_l, bus.i_sample_r};
      end else if (consume) begin
         pend_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: if (pend_q) begin
            work_d = pair_q;
            ch_d   = 1'b0;
         end
         ST_ISSUE: begin
            cnt_d  = '0;
            data_d = word_now;
         end
         ST_WAIT_ACK:  if (bus.i_spi_cs && cnt_q != ACK_LAST) cnt_d = cnt_q + CNT_W'(1);
         ST_WAIT_DONE: if (bus.i_spi_cs) cnt_d = '0;
         ST_HOLDOFF: begin
            if (cnt_q == HOLD_LAST) ch_d = 1'b1;
            else                    cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Word is shown live during ISSUE so it is valid alongside the send pulse.
   always_comb begin
      bus.o_send    = (state_q == ST_ISSUE);
      bus.o_busy    = (state_q != ST_IDLE);
      bus.o_data    = (state_q == ST_ISSUE) ? word_now : data_q;
      bus.o_error   = (state_q == ST_WAIT_ACK) && bus.i_spi_cs && (cnt_q == ACK_LAST);
      bus.o_overrun = ovr_q;
   end

endmodule
